// File: rtl/mux_share_pkg.sv
// Shared types and constants for the two-requester mux arbiter.
package mux_share_pkg;
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      OWN_X = 2'd1,
      OWN_Y = 2'd2
   } state_e;

   localparam logic SEL_X = 1'b0;
   localparam logic SEL_Y = 1'b1;

   localparam int DEFAULT_WIDTH = 4;
endpackage

// File: rtl/mux_share_arbiter_mux2to1_w.sv
// Width-parameterised combinational 2-to-1 mux; s = 0 picks a, s = 1 picks b.
module mux2to1_w
   import mux_share_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             s,
   output logic [WIDTH-1:0] y
);
   assign y = (s == SEL_Y) ? b : a;
endmodule

// File: rtl/mux_share_arbiter.sv
// Round-robin owner of the shared X/Y mux with a bounded tenure under contention.
module mux_share_arbiter
   import mux_share_pkg::*;
#(
   parameter int WIDTH      = DEFAULT_WIDTH,
   parameter int MAX_TENURE = 4
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             ReqX,
   input  logic             ReqY,
   input  logic [WIDTH-1:0] X,
   input  logic [WIDTH-1:0] Y,
   output logic             GntX,
   output logic             GntY,
   output logic             Sel,
   output logic             Valid,
   output logic [WIDTH-1:0] M
);
   // A tenure of 1 still needs a 1-bit counter so the compare has something to look at.
   localparam int CNT_W = (MAX_TENURE > 1) ? $clog2(MAX_TENURE) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_TENURE - 1);

   state_e           state_q, state_d;
   logic             last_q, last_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             sel_q, sel_d;
   logic [WIDTH-1:0] m_q, m_d;
   logic [WIDTH-1:0] m_mux;
   logic             grant_edge;

   mux2to1_w #(.WIDTH(WIDTH)) u_mux (
      .a (X),
      .b (Y),
      .s (sel_d),
      .y (m_mux)
   );

   // Next-state, tenure counter, round-robin pointer and captured select/data.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (ReqX && ReqY)  state_d = (last_q == SEL_X) ? OWN_Y : OWN_X;
            else if (ReqX)     state_d = OWN_X;
            else if (ReqY)     state_d = OWN_Y;
         end
         OWN_X: begin
            if (!ReqX)                         state_d = ReqY ? OWN_Y : IDLE;
            else if (ReqY && cnt_q == CNT_MAX) state_d = OWN_Y;
         end
         OWN_Y: begin
            if (!ReqY)                         state_d = ReqX ? OWN_X : IDLE;
            else if (ReqX && cnt_q == CNT_MAX) state_d = OWN_X;
         end
         default: state_d = IDLE;
      endcase

      grant_edge = (state_d != IDLE) && (state_d != state_q);

      // Counter restarts on every new grant, counts retained cycles, and saturates.
      cnt_d = '0;
      if (!grant_edge && state_d != IDLE && cnt_q != CNT_MAX)
         cnt_d = cnt_q + 1'b1;
      else if (!grant_edge && state_d != IDLE)
         cnt_d = cnt_q;

      last_d = last_q;
      if (grant_edge) last_d = (state_d == OWN_Y) ? SEL_Y : SEL_X;

      sel_d = sel_q;
      if (state_d == OWN_X)      sel_d = SEL_X;
      else if (state_d == OWN_Y) sel_d = SEL_Y;

      m_d = (state_d == IDLE) ? m_q : m_mux;
   end

   // State and output registers; reset leaves Last = Y so X wins the first tie.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state_q <= IDLE;
         last_q  <= SEL_Y;
         cnt_q   <= '0;
         sel_q   <= SEL_X;
         m_q     <= '0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
         sel_q   <= sel_d;
         m_q     <= m_d;
      end
   end

   assign GntX  = (state_q == OWN_X);
   assign GntY  = (state_q == OWN_Y);
   assign Valid = GntX | GntY;
   assign Sel   = sel_q;
   assign M     = m_q;
endmodule

// File: doc/mux_share_arbiter.md
# mux_share_arbiter

Round-robin arbiter that shares the 4-bit 2-to-1 switch multiplexer datapath between two requesters, X and Y. It sequences the mux select from request/grant handshakes and limits how long one owner can keep the output while the other waits. It registers the selected word for the LED output stage. It sits between the requester logic and the LEDR display path, and drives the same select semantics as the board mux: s = 0 selects X, s = 1 selects Y.

## Interface
- WIDTH, 4: data width of X, Y and M.
- MAX_TENURE, 4: maximum cycles one owner holds the mux while the other requests; legal range ≥ 1.
- Clock  in  1  single system clock; all state changes on its rising edge.
- Reset  in  1  asynchronous, active-high reset.
- ReqX  in  1  requester X wants the output; held high for the whole tenure.
- ReqY  in  1  requester Y wants the output.
- X  in  WIDTH  requester X data; sampled every edge while X owns or is being granted.
- Y  in  WIDTH  requester Y data.
- GntX  out  1  X owns the mux (registered).
- GntY  out  1  Y owns the mux (registered).
- Sel  out  1  mux select, 0 = X, 1 = Y (registered); holds its last value when idle.
- Valid  out  1  M carries current owner data (= GntX | GntY).
- M  out  WIDTH  registered mux output; holds its last value when idle.

## Operation
- FSM states: IDLE, OWN_X, OWN_Y. Pointer Last (1 bit) records the last granted side.
- IDLE:
  - only ReqX → OWN_X; only ReqY → OWN_Y.
  - both requesting → grant the side ≠ Last.
  - neither → stay in IDLE.
- OWN_X (OWN_Y symmetric):
  - ReqX low → OWN_Y if ReqY, else IDLE.
  - ReqX high, ReqY high, Cnt == MAX_TENURE-1 → OWN_Y (preempt).
  - otherwise stay.
- Cnt:
  - cleared to 0 on every edge that enters an OWN state, including a direct X→Y switch.
  - +1 each edge the owner is retained; saturates at MAX_TENURE-1.
  - width $clog2(MAX_TENURE); forced 1 bit when MAX_TENURE = 1.
- Last updates on every grant edge to the newly granted side.
- M/Sel: on any edge whose next state is OWN_x, Sel ← that side and M ← that side's input. In IDLE, M and Sel hold.
- Owner drop and other-side request on the same edge → direct switch with no idle bubble.
- MAX_TENURE = 1 with both sides requesting continuously → strict alternation every cycle.
- Owner data for the edge where its Req is sampled low is not captured.

## Timing
- Reset: state IDLE, Last = 1 (so X wins the first tie), Cnt = 0, GntX = GntY = 0, Valid = 0, Sel = 0, M = 0; all applied asynchronously.
- Reset mid-tenure: outputs clear immediately. The first grant after deassertion follows the reset tie rule.
- Grant latency: 1 cycle. Req sampled high at edge k → Gnt/Valid/Sel/M valid after edge k.
- Data latency: 1 cycle. M after edge k equals the owner's input at edge k.
- Release latency: 1 cycle. Req low at edge k → Gnt low after edge k.
- Under contention an owner holds exactly MAX_TENURE consecutive cycles. The waiting side is granted within MAX_TENURE cycles of its request.
- GntX and GntY are never both high.

## Structure
- Package mux_share_pkg:
  - state enum {IDLE, OWN_X, OWN_Y}
  - constants SEL_X = 1'b0, SEL_Y = 1'b1
  - default WIDTH = 4
- Sub-module mux2to1_w (WIDTH-parameterised combinational 2-to-1 mux) supplies the next-M value from Sel_next. The FSM, counter and output registers stay in the top module.

## Test plan
- Reset, then ReqX = 1, X = 4'hA for 3 cycles, then drop → GntX = 1, Sel = 0, M = 4'hA one cycle after the request; GntX = 0 one cycle after the drop; M stays 4'hA.
- ReqX and ReqY rise together after reset, X = 4'h3, Y = 4'hC → X granted first. X drops after 2 cycles → GntY the next cycle with no idle cycle, M = 4'hC.
- MAX_TENURE = 4, both held high continuously → grants alternate X, X, X, X, Y, Y, Y, Y, X…; never both high.
- Only Y requests for 10 cycles → GntY stays high throughout (no preemption without contention); Cnt saturates at 3.
- Assert Reset while OWN_Y with M = 4'h5 → all outputs 0 before the next edge. After release with both requesting → X granted first.
- MAX_TENURE = 1, both requesting, X = 4'h1, Y = 4'h2 → M alternates 1, 2, 1, 2 every cycle; Sel toggles every cycle.
